// File: rtl/aes_round_transform.sv
// Single-cycle AES state transform: SubBytes, ShiftRows, MixColumns or a
// full non-final round (without AddRoundKey), with a registered result.
module aes_round_transform (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [127:0] state_in,
    output logic [127:0] state_out,
    output logic         valid
);

    // FIPS-197 S-box, entry x at bits [2047-8x -: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = 11'd2047 - {x, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
        return o;
    endfunction

    // Byte (r,c) takes the byte at (r,(c+r) mod 4)
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((c + r) % 4) + r;
                o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = xtime(a0);
        b1 = xtime(a1);
        b2 = xtime(a2);
        b3 = xtime(a3);
        return {b0 ^ b1 ^ a1 ^ a2 ^ a3,
                a0 ^ b1 ^ b2 ^ a2 ^ a3,
                a0 ^ a1 ^ b2 ^ b3 ^ a3,
                b0 ^ a0 ^ a1 ^ a2 ^ b3};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        return o;
    endfunction

    logic [127:0] result;

    always_comb begin
        result = '0;
        unique case (op)
            2'd0: result = sub_bytes(state_in);
            2'd1: result = shift_rows(state_in);
            2'd2: result = mix_columns(state_in);
            2'd3: result = mix_columns(shift_rows(sub_bytes(state_in)));
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_out <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= start;
            if (start)
                state_out <= result;
        end
    end

endmodule

// File: tb/tb_aes_round_transform.sv
// Directed-vector bench for aes_round_transform using FIPS-197
// round-1 example vectors and hand-computed boundary values.
module tb_aes_round_transform;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [127:0] state_in;
    logic [127:0] state_out;
    logic         valid;

    int tests;
    int fails;

    localparam logic [127:0] V_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] V_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] V_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] V_MC  = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] C_IN  = 128'hdb135345010101010101010101010101;
    localparam logic [127:0] C_OUT = 128'h8e4da1bc010101010101010101010101;

    aes_round_transform dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .state_in  (state_in),
        .state_out (state_out),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic issue(input logic [1:0] o, input logic [127:0] d);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        state_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        start    = 1'b0;
        op       = 2'($urandom_range(0, 3));
        state_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        op       = 2'd3;
        state_in = V_IN;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (state_out !== 128'h0) begin
                fails++;
                $display("FAIL reset_out[%0d]: got %h want 0", i, state_out);
            end
            tests++;
            if (valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_valid[%0d]: got %b want 0", i, valid);
            end
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (valid !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_valid[%0d]: got %b want 0", i, valid);
            end
        end
    endtask

    task automatic test_sub_bytes();
        logic [127:0] vin [3];
        logic [127:0] vexp [3];
        vin[0] = V_IN;  vexp[0] = V_SB;
        vin[1] = '0;    vexp[1] = {16{8'h63}};
        vin[2] = '1;    vexp[2] = {16{8'h16}};
        for (int i = 0; i < 3; i++) begin
            issue(2'd0, vin[i]);
            tests++;
            if (state_out !== vexp[i] || valid !== 1'b1) begin
                fails++;
                $display("FAIL sub_bytes[%0d]: got %h v=%b want %h v=1",
                         i, state_out, valid, vexp[i]);
            end
            idle();
        end
    endtask

    task automatic test_shift_rows();
        issue(2'd1, V_SB);
        tests++;
        if (state_out !== V_SR || valid !== 1'b1) begin
            fails++;
            $display("FAIL shift_rows: got %h v=%b want %h v=1",
                     state_out, valid, V_SR);
        end
        idle();
    endtask

    task automatic test_mix_columns();
        issue(2'd2, V_SR);
        tests++;
        if (state_out !== V_MC || valid !== 1'b1) begin
            fails++;
            $display("FAIL mix_columns: got %h v=%b want %h v=1",
                     state_out, valid, V_MC);
        end
        issue(2'd2, C_IN);
        tests++;
        if (state_out !== C_OUT || valid !== 1'b1) begin
            fails++;
            $display("FAIL mix_column_single: got %h v=%b want %h v=1",
                     state_out, valid, C_OUT);
        end
        idle();
    endtask

    task automatic test_full_round();
        issue(2'd3, V_IN);
        tests++;
        if (state_out !== V_MC || valid !== 1'b1) begin
            fails++;
            $display("FAIL full_round: got %h v=%b want %h v=1",
                     state_out, valid, V_MC);
        end
    endtask

    task automatic test_hold();
        idle();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if (valid !== 1'b0 || state_out !== V_MC) begin
                fails++;
                $display("FAIL hold[%0d]: got %h v=%b want %h v=0",
                         i, state_out, valid, V_MC);
            end
            idle();
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]   bop  [3];
        logic [127:0] bin  [3];
        logic [127:0] bexp [3];
        bop[0] = 2'd0; bin[0] = V_IN; bexp[0] = V_SB;
        bop[1] = 2'd1; bin[1] = V_SB; bexp[1] = V_SR;
        bop[2] = 2'd2; bin[2] = V_SR; bexp[2] = V_MC;
        for (int i = 0; i < 3; i++) begin
            issue(bop[i], bin[i]);
            tests++;
            if (state_out !== bexp[i] || valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b[%0d]: got %h v=%b want %h v=1",
                         i, state_out, valid, bexp[i]);
            end
        end
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        op       = 2'd3;
        state_in = V_IN;
        @(posedge clk);
        #1;
        tests++;
        if (state_out !== 128'h0 || valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_reset: got %h v=%b want 0 v=0",
                     state_out, valid);
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_after_reset: got v=%b want v=0", valid);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'd0;
        state_in = '0;
        test_reset();
        test_sub_bytes();
        test_shift_rows();
        test_mix_columns();
        test_full_round();
        test_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_transform.md
Name: aes_round_transform

Overview:
- Single-cycle AES (FIPS-197) state transform datapath used by the AES-256 round controller.
- Applies one of SubBytes, ShiftRows or MixColumns to a full 128-bit state, or all three in sequence as a non-final round without AddRoundKey.
- Result is registered; one operation may be issued per clock.

Parameters:
None. The state width is fixed at 128 bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  issue an operation this cycle
op  input  2  0=SubBytes, 1=ShiftRows, 2=MixColumns, 3=full round (SubBytes, then ShiftRows, then MixColumns)
state_in  input  128  input AES state
state_out  output  128  registered result
valid  output  1  one-cycle pulse; state_out updated this cycle

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Byte mapping (column-major):
  - Byte k occupies state[127-8k -: 8], k = 0..15.
  - Byte k sits at row = k mod 4, column = k div 4.
  - Column c occupies state[127-32c -: 32]; its top byte is row 0.
- SubBytes: every byte is replaced by its FIPS-197 S-box value, using a 256-entry constant table. Examples: 00->63, 01->7c, 53->ed, ff->16. All 16 bytes are substituted in parallel.
- ShiftRows:
  - Row r is rotated left by r columns: out(r,c) = in(r,(c+r) mod 4).
  - Row 0 is unchanged.
- MixColumns, applied per column over GF(2^8) with polynomial 0x11b:
  - o0 = 2a0 ^ 3a1 ^ a2 ^ a3
  - o1 = a0 ^ 2a1 ^ 3a2 ^ a3
  - o2 = a0 ^ a1 ^ 2a2 ^ 3a3
  - o3 = 3a0 ^ a1 ^ a2 ^ 2a3
  - xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0); 3x = xtime(x) ^ x.
- op=3 chains the three functions combinationally, in the order SubBytes, ShiftRows, MixColumns.
- Timing:
  - The result is captured at the rising edge on which start=1. state_out and valid=1 are visible from that edge until the next edge (latency 1).
  - Back-to-back starts are allowed, one result per cycle, with no stall.
  - start=0: valid goes low at the next edge and state_out holds its last value.
- Reset:
  - rst=1 at an edge sets state_out=0 and valid=0.
  - rst has priority over a coincident start; that operation is dropped and produces no valid.
  - Reset mid-stream loses no internal context, because the block has no other state.
- state_in and op are sampled only at an edge where start=1. At other times they may change freely.
- No X propagation from the S-box: every table entry is defined.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with start=1 and any state_in -> state_out=0, valid=0. Release rst -> valid stays 0 until a start is issued.
2. SubBytes, op=0: state_in=193de3bea0f4e22b9ac68d2ae9f84808 -> next cycle state_out=d42711aee0bf98f1b8b45de51e415230, valid=1. Also state_in=all 00 -> all 63; all ff -> all 16.
3. ShiftRows, op=1: state_in=d42711aee0bf98f1b8b45de51e415230 -> state_out=d4bf5d30e0b452aeb84111f11e2798e5.
4. MixColumns, op=2: state_in=d4bf5d30e0b452aeb84111f11e2798e5 -> state_out=046681e5e0cb199a48f8d37a2806264c. Also a single column db135345 -> 8e4da1bc, with other columns 01010101 -> 01010101.
5. Full round, op=3: state_in=193de3bea0f4e22b9ac68d2ae9f84808 -> state_out=046681e5e0cb199a48f8d37a2806264c in one cycle.
6. Pipelining: issue op=0, 1, 2 on three consecutive cycles with the vectors from scenarios 2-4 -> three consecutive valid pulses with the matching outputs. Assert rst together with the 4th start -> no valid, state_out=0.
